// File: rtl/master_cmd_sequencer_if.sv
// Single-beat request/acknowledge bus between the command sequencer and a master core.
// The sequencer holds slave/addr/wdata stable while m_req is high; m_ack is a one-cycle pulse.
interface master_cmd_sequencer_if #(
    parameter int unsigned SLAVE_LEN = 2,
    parameter int unsigned ADDR_LEN  = 12,
    parameter int unsigned DATA_LEN  = 8
);
    logic                 m_req;
    logic                 m_rw;
    logic [SLAVE_LEN-1:0] m_slave;
    logic [ADDR_LEN-1:0]  m_addr;
    logic [DATA_LEN-1:0]  m_wdata;
    logic                 m_ack;
    logic [DATA_LEN-1:0]  m_rdata;

    modport master (
        output m_req, m_rw, m_slave, m_addr, m_wdata,
        input  m_ack, m_rdata
    );

    modport slave (
        input  m_req, m_rw, m_slave, m_addr, m_wdata,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/master_cmd_sequencer.sv
// Turns read/write button rising edges into a burst of single-beat bus requests,
// stepping address and write data per beat and reporting busy/done/err status.
module master_cmd_sequencer #(
    parameter int unsigned SLAVE_LEN = 2,
    parameter int unsigned ADDR_LEN  = 12,
    parameter int unsigned DATA_LEN  = 8,
    parameter int unsigned BURST_LEN = 12,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [DATA_LEN-1:0]  data_i,
    input  logic [ADDR_LEN:0]    address_i,
    input  logic [SLAVE_LEN-1:0] slave_i,
    input  logic [BURST_LEN:0]   burst_num_i,
    master_cmd_sequencer_if.master bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [DATA_LEN-1:0]  rd_data_o,
    output logic                 rd_valid_o,
    output logic [BURST_LEN:0]   beat_cnt_o
);

    localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0]     TmoLast = TmoW'(TIMEOUT - 2);
    localparam logic [TmoW-1:0]     TmoOne  = TmoW'(1);
    localparam logic [BURST_LEN:0]  BeatOne = (BURST_LEN + 1)'(1);
    localparam logic [ADDR_LEN-1:0] AddrOne = ADDR_LEN'(1);

    typedef enum logic [1:0] {StIdle, StIssue, StGap, StFinish} state_e;

    state_e               state_q;
    logic                 rd_lvl_q, rd_prev_q, wr_lvl_q, wr_prev_q;
    logic                 req_q, rw_q, busy_q, done_q, err_q, rd_valid_q;
    logic [SLAVE_LEN-1:0] slave_q;
    logic [ADDR_LEN-1:0]  addr_q;
    logic [DATA_LEN-1:0]  base_q, wdata_q, rd_data_q;
    logic [BURST_LEN:0]   count_q, beat_cnt_q;
    logic [TmoW-1:0]      tmo_q;

    logic                 read_rise, write_rise;
    logic [BURST_LEN:0]   next_beat;
    logic [DATA_LEN-1:0]  gap_wdata;
    logic                 unused_addr_msb;

    // Levels are sampled once before edge detection, so m_req rises two edges after the button.
    assign read_rise       = rd_lvl_q & ~rd_prev_q;
    assign write_rise      = wr_lvl_q & ~wr_prev_q;
    assign next_beat       = beat_cnt_q + BeatOne;
    assign gap_wdata       = base_q + DATA_LEN'(beat_cnt_q);
    assign unused_addr_msb = address_i[ADDR_LEN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rd_lvl_q   <= 1'b0;
            rd_prev_q  <= 1'b0;
            wr_lvl_q   <= 1'b0;
            wr_prev_q  <= 1'b0;
            req_q      <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            slave_q    <= '0;
            addr_q     <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
            tmo_q      <= '0;
        end else begin
            rd_lvl_q   <= read_i;
            rd_prev_q  <= rd_lvl_q;
            wr_lvl_q   <= write_i;
            wr_prev_q  <= wr_lvl_q;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (read_rise && write_rise) begin
                        err_q <= 1'b1;
                    end else if (read_rise || write_rise) begin
                        slave_q    <= slave_i;
                        addr_q     <= address_i[ADDR_LEN-1:0];
                        base_q     <= data_i;
                        wdata_q    <= data_i;
                        count_q    <= (burst_num_i == '0) ? BeatOne : burst_num_i;
                        rw_q       <= read_rise;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        req_q      <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.m_ack) begin
                        req_q      <= 1'b0;
                        beat_cnt_q <= next_beat;
                        if (rw_q) begin
                            rd_data_q  <= bus.m_rdata;
                            rd_valid_q <= 1'b1;
                        end
                        state_q <= (next_beat == count_q) ? StFinish : StGap;
                    end else if (tmo_q == TmoLast) begin
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + TmoOne;
                    end
                end
                StGap: begin
                    addr_q  <= addr_q + AddrOne;
                    wdata_q <= gap_wdata;
                    req_q   <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= StIssue;
                end
                StFinish: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.m_req   = req_q;
    assign bus.m_rw    = rw_q;
    assign bus.m_slave = slave_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rd_data_o   = rd_data_q;
    assign rd_valid_o  = rd_valid_q;
    assign beat_cnt_o  = beat_cnt_q;

endmodule

// File: tb/tb_master_cmd_sequencer.sv
// Directed bench for master_cmd_sequencer: background ack responder and pulse/beat monitor,
// with a linear list of command scenarios checked by immediate assertions.
module tb_master_cmd_sequencer;

    localparam int unsigned SLAVE_LEN = 2;
    localparam int unsigned ADDR_LEN  = 12;
    localparam int unsigned DATA_LEN  = 8;
    localparam int unsigned BURST_LEN = 12;
    localparam int unsigned TIMEOUT   = 8;
    localparam int          AckLat    = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 read, write;
    logic [DATA_LEN-1:0]  data;
    logic [ADDR_LEN:0]    address;
    logic [SLAVE_LEN-1:0] slave;
    logic [BURST_LEN:0]   burst_num;
    logic                 busy, done, err, rd_valid;
    logic [DATA_LEN-1:0]  rd_data;
    logic [BURST_LEN:0]   beat_cnt;

    master_cmd_sequencer_if #(
        .SLAVE_LEN(SLAVE_LEN), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)
    ) bus ();

    master_cmd_sequencer #(
        .SLAVE_LEN(SLAVE_LEN), .ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN),
        .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_i     (read),
        .write_i    (write),
        .data_i     (data),
        .address_i  (address),
        .slave_i    (slave),
        .burst_num_i(burst_num),
        .bus        (bus.master),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .beat_cnt_o (beat_cnt)
    );

    always #5 clk = ~clk;

    // Ack responder: m_ack is driven 3 cycles after m_req rises, sampled on the 4th edge.
    logic                ack_en = 1'b0;
    int                  ack_n = 0;
    int                  req_age = 0;
    logic [DATA_LEN-1:0] rdata_tbl [0:63];

    always @(posedge clk) begin
        #1;
        bus.m_ack = 1'b0;
        if (bus.m_req) req_age++;
        else req_age = 0;
        if (ack_en && bus.m_req && req_age == AckLat + 1) begin
            bus.m_ack   = 1'b1;
            bus.m_rdata = rdata_tbl[ack_n % 64];
            ack_n++;
        end
    end

    // Monitor: cycle counts of status signals and one record per request.
    int   req_hi = 0, busy_hi = 0, idle_busy = 0, done_n = 0, err_n = 0, rdv_n = 0;
    logic req_prev = 1'b0;
    logic [ADDR_LEN-1:0]  q_addr [$];
    logic [DATA_LEN-1:0]  q_wdata[$];
    logic                 q_rw   [$];
    logic [SLAVE_LEN-1:0] q_slave[$];

    always @(negedge clk) begin
        if (bus.m_req) req_hi++;
        if (busy) busy_hi++;
        if (busy && !bus.m_req) idle_busy++;
        if (done) done_n++;
        if (err) err_n++;
        if (rd_valid) rdv_n++;
        if (bus.m_req && !req_prev) begin
            q_addr.push_back(bus.m_addr);
            q_wdata.push_back(bus.m_wdata);
            q_rw.push_back(bus.m_rw);
            q_slave.push_back(bus.m_slave);
        end
        req_prev = bus.m_req;
    end

    int tests = 0;
    int fails = 0;
    int r0, h0, b0, i0, d0, e0, v0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic snap();
        r0 = q_addr.size();
        h0 = req_hi;
        b0 = busy_hi;
        i0 = idle_busy;
        d0 = done_n;
        e0 = err_n;
        v0 = rdv_n;
    endtask

    task automatic setup(input logic [SLAVE_LEN-1:0] s, input logic [ADDR_LEN:0] a,
                         input logic [DATA_LEN-1:0] d, input logic [BURST_LEN:0] n);
        slave     = s;
        address   = a;
        data      = d;
        burst_num = n;
    endtask

    logic hit;

    initial begin
        for (int i = 0; i < 64; i++) rdata_tbl[i] = '0;
        bus.m_rdata = '0;
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        setup(2'd0, 13'h0, 8'h0, 13'd0);
        ticks(3);

        check("rst_m_req", 32'(bus.m_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check("rst_pulses", 32'({done, err, rd_valid}), 32'd0);
        check("rst_addr", 32'(bus.m_addr), 32'd0);
        reset = 1'b0;
        ack_en = 1'b1;
        ticks(2);

        // Single write beat; address bit 12 set to show it is ignored.
        snap();
        setup(2'd2, 13'h1010, 8'h5A, 13'd1);
        write = 1'b1;
        tick();
        check("w1_latency_low", 32'(bus.m_req), 32'd0);
        tick();
        check("w1_latency_req", 32'(bus.m_req), 32'd1);
        ticks(20);
        write = 1'b0;
        check("w1_nreq", 32'(q_addr.size() - r0), 32'd1);
        check("w1_rw", 32'(q_rw[r0]), 32'd0);
        check("w1_addr", 32'(q_addr[r0]), 32'h010);
        check("w1_wdata", 32'(q_wdata[r0]), 32'h5A);
        check("w1_slave", 32'(q_slave[r0]), 32'd2);
        check("w1_done", 32'(done_n - d0), 32'd1);
        check("w1_beat_cnt", 32'(beat_cnt), 32'd1);
        check("w1_busy_cycles", 32'(busy_hi - b0), 32'd5);
        ticks(2);

        // Read burst of 3 wrapping the address space.
        snap();
        rdata_tbl[ack_n % 64]       = 8'h11;
        rdata_tbl[(ack_n + 1) % 64] = 8'h22;
        rdata_tbl[(ack_n + 2) % 64] = 8'h33;
        setup(2'd1, 13'h0FFE, 8'h00, 13'd3);
        read = 1'b1;
        ticks(30);
        read = 1'b0;
        check("r3_nreq", 32'(q_addr.size() - r0), 32'd3);
        check("r3_addr0", 32'(q_addr[r0]), 32'hFFE);
        check("r3_addr1", 32'(q_addr[r0 + 1]), 32'hFFF);
        check("r3_addr2", 32'(q_addr[r0 + 2]), 32'h000);
        check("r3_rw", 32'(q_rw[r0 + 2]), 32'd1);
        check("r3_idle_in_burst", 32'(idle_busy - i0), 32'd3);
        check("r3_rd_valid", 32'(rdv_n - v0), 32'd3);
        check("r3_rd_data", 32'(rd_data), 32'h33);
        check("r3_done", 32'(done_n - d0), 32'd1);
        check("r3_beat_cnt", 32'(beat_cnt), 32'd3);
        ticks(2);

        // Write burst of 4 with data wrap; inputs change mid-burst.
        snap();
        setup(2'd3, 13'h0100, 8'hFE, 13'd4);
        write = 1'b1;
        ticks(3);
        setup(2'd0, 13'h0555, 8'h00, 13'd9);
        ticks(30);
        write = 1'b0;
        check("w4_nreq", 32'(q_addr.size() - r0), 32'd4);
        check("w4_wdata0", 32'(q_wdata[r0]), 32'hFE);
        check("w4_wdata1", 32'(q_wdata[r0 + 1]), 32'hFF);
        check("w4_wdata2", 32'(q_wdata[r0 + 2]), 32'h00);
        check("w4_wdata3", 32'(q_wdata[r0 + 3]), 32'h01);
        check("w4_addr3", 32'(q_addr[r0 + 3]), 32'h103);
        check("w4_slave3", 32'(q_slave[r0 + 3]), 32'd3);
        check("w4_beat_cnt", 32'(beat_cnt), 32'd4);
        ticks(2);

        // burst_num of 0 behaves as a single beat.
        snap();
        setup(2'd1, 13'h0020, 8'h42, 13'd0);
        write = 1'b1;
        ticks(20);
        write = 1'b0;
        check("b0_nreq", 32'(q_addr.size() - r0), 32'd1);
        check("b0_beat_cnt", 32'(beat_cnt), 32'd1);
        check("b0_done", 32'(done_n - d0), 32'd1);
        ticks(2);

        // Simultaneous read and write edges are rejected.
        snap();
        read  = 1'b1;
        write = 1'b1;
        ticks(8);
        read  = 1'b0;
        write = 1'b0;
        check("rw_err", 32'(err_n - e0), 32'd1);
        check("rw_nreq", 32'(q_addr.size() - r0), 32'd0);
        check("rw_busy", 32'(busy_hi - b0), 32'd0);
        ticks(2);

        // Read held across completion must not retrigger.
        snap();
        setup(2'd0, 13'h0040, 8'h00, 13'd1);
        read = 1'b1;
        ticks(35);
        check("hold_nreq", 32'(q_addr.size() - r0), 32'd1);
        check("hold_done", 32'(done_n - d0), 32'd1);
        read = 1'b0;
        ticks(2);

        // No acknowledge: abort after TIMEOUT-1 request cycles.
        ack_en = 1'b0;
        snap();
        setup(2'd1, 13'h0080, 8'h00, 13'd2);
        write = 1'b1;
        ticks(25);
        write = 1'b0;
        check("tmo_req_cycles", 32'(req_hi - h0), 32'd7);
        check("tmo_err", 32'(err_n - e0), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_beat_cnt", 32'(beat_cnt), 32'd0);
        check("tmo_no_done", 32'(done_n - d0), 32'd0);
        ticks(2);

        // Asynchronous reset in the middle of a burst.
        ack_en = 1'b1;
        setup(2'd2, 13'h0200, 8'h10, 13'd5);
        write = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick();
            if (beat_cnt >= 13'd2 && bus.m_req) hit = 1'b1;
        end
        check("mid_reached", 32'(hit), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_m_req", 32'(bus.m_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
        write = 1'b0;
        ticks(2);
        reset = 1'b0;
        ticks(2);
        snap();
        setup(2'd2, 13'h0300, 8'h20, 13'd2);
        write = 1'b1;
        ticks(25);
        write = 1'b0;
        check("fresh_nreq", 32'(q_addr.size() - r0), 32'd2);
        check("fresh_addr0", 32'(q_addr[r0]), 32'h300);
        check("fresh_wdata1", 32'(q_wdata[r0 + 1]), 32'h21);
        check("fresh_done", 32'(done_n - d0), 32'd1);
        check("fresh_beat_cnt", 32'(beat_cnt), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
